// File: rtl/line_prefetch_buffer.sv
// Ping-pong scanline buffer in the pixel clock domain: requests the next line from the DRAM
// fetch engine, stores its pixel stream and replays it to the DVI transmitter aligned to de.
module line_prefetch_buffer #(
  parameter int unsigned H_ACTIVE       = 1280,
  parameter int unsigned V_ACTIVE       = 720,
  parameter int unsigned ADDR_W         = 11,
  parameter logic [23:0] UNDERRUN_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        framestart,
  input  logic        linestart,
  input  logic        prefetch_line,
  input  logic        de,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [9:0]  req_line,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [23:0] px_data,
  output logic [7:0]  d_red,
  output logic [7:0]  d_green,
  output logic [7:0]  d_blue,
  output logic        err_underrun,
  input  logic        clr_err
);

  // One extra bit so a full line (H_ACTIVE may equal 2**ADDR_W) is representable.
  localparam int unsigned     CntW  = ADDR_W + 1;
  localparam logic [CntW-1:0] HCnt  = CntW'(H_ACTIVE);
  localparam logic [9:0]      VLast = 10'(V_ACTIVE - 1);

  typedef enum logic [2:0] {StIdle, StReq, StFill, StDone, StDrain} state_e;

  state_e          state_q, state_d;
  logic [9:0]      req_line_q, req_line_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d, wr_cnt_inc, ls_cnt;
  logic            fill_bank_q, fill_bank_d;
  logic [CntW-1:0] disp_cnt_q, disp_cnt_d;
  logic [CntW-1:0] rd_ptr_q, rd_ptr_d, rd_next, rd_idx;
  logic            preload_q;
  logic [23:0]     pix_q, pix_d, rd_data;
  logic            err_q, err_d, err_fill, err_rd;
  logic            wr_en;

  // Both banks in one array, bank select is the address MSB.
  logic [23:0]     mem [2**CntW];

  assign wr_cnt_inc = wr_cnt_q + CntW'(1);
  assign wr_en      = (state_q == StFill) && px_valid;

  always_comb begin
    state_d     = state_q;
    req_line_d  = req_line_q;
    wr_cnt_d    = wr_cnt_q;
    fill_bank_d = fill_bank_q;
    disp_cnt_d  = disp_cnt_q;
    ls_cnt      = '0;
    err_fill    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (prefetch_line) state_d = StReq;
      end
      StReq: begin
        if (req_ready) begin
          state_d    = StFill;
          wr_cnt_d   = '0;
          req_line_d = (req_line_q == VLast) ? '0 : req_line_q + 10'd1;
        end
      end
      StFill: begin
        if (px_valid) begin
          wr_cnt_d = wr_cnt_inc;
          if (wr_cnt_inc == HCnt) state_d = StDone;
        end
      end
      StDone: begin
      end
      StDrain: begin
        if (px_valid) begin
          wr_cnt_d = wr_cnt_inc;
          if (wr_cnt_inc == HCnt) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (prefetch_line && (state_q != StIdle)) err_fill = 1'b1;

    if (linestart) begin
      fill_bank_d = ~fill_bank_q;
      // wr_cnt_d already includes a beat landing in this same cycle.
      if ((state_q == StFill) || (state_q == StDone)) ls_cnt = wr_cnt_d;
      disp_cnt_d = ls_cnt;
      case (state_q)
        StDone: state_d = StIdle;
        StFill: begin
          if (ls_cnt == HCnt) begin
            state_d = StIdle;
          end else begin
            state_d  = StDrain;
            err_fill = 1'b1;
          end
        end
        StReq: begin
          // A handshake in this cycle is already visible to the fetch engine: drain its line.
          err_fill = 1'b1;
          state_d  = req_ready ? StDrain : StIdle;
        end
        default: begin
        end
      endcase
    end

    if (framestart) req_line_d = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{fill_bank_q, wr_cnt_q[ADDR_W-1:0]}] <= px_data;
  end

  // Read pointer saturates at H_ACTIVE so an overlong de keeps reading the underrun colour.
  assign rd_next = (rd_ptr_q == HCnt) ? HCnt : rd_ptr_q + CntW'(1);
  assign rd_idx  = preload_q ? '0 : rd_next;
  assign rd_data = (rd_idx < disp_cnt_q) ? mem[{~fill_bank_q, rd_idx[ADDR_W-1:0]}]
                                         : UNDERRUN_COLOR;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    pix_d    = pix_q;
    err_rd   = 1'b0;
    if (linestart) begin
      rd_ptr_d = '0;
    end else if (preload_q) begin
      pix_d = rd_data;
    end else if (de) begin
      err_rd   = (rd_ptr_q >= disp_cnt_q);
      rd_ptr_d = rd_next;
      pix_d    = rd_data;
    end
  end

  assign err_d = (err_fill || err_rd) ? 1'b1 : (clr_err ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      req_line_q  <= '0;
      wr_cnt_q    <= '0;
      fill_bank_q <= 1'b0;
      disp_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      preload_q   <= 1'b0;
      pix_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_line_q  <= req_line_d;
      wr_cnt_q    <= wr_cnt_d;
      fill_bank_q <= fill_bank_d;
      disp_cnt_q  <= disp_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      preload_q   <= linestart;
      pix_q       <= pix_d;
      err_q       <= err_d;
    end
  end

  assign req_valid    = (state_q == StReq);
  assign px_ready     = (state_q == StFill) || (state_q == StDrain);
  assign req_line     = req_line_q;
  assign d_red        = pix_q[23:16];
  assign d_green      = pix_q[15:8];
  assign d_blue       = pix_q[7:0];
  assign err_underrun = err_q;

endmodule

// File: tb/tb_line_prefetch_buffer.sv
// Bench for line_prefetch_buffer: scenario tasks with randomized pixel data and timing,
// checked against a queue-based model of delivered lines, line indices and the error flag.
module tb_line_prefetch_buffer;

  localparam int          H  = 8;
  localparam int          V  = 3;
  localparam logic [23:0] UC = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        framestart, linestart, prefetch_line, de;
  logic        req_valid, req_ready;
  logic [9:0]  req_line;
  logic        px_valid, px_ready;
  logic [23:0] px_data;
  logic [7:0]  d_red, d_green, d_blue;
  logic        err_underrun, clr_err;

  line_prefetch_buffer #(
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .ADDR_W         (3),
    .UNDERRUN_COLOR (UC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .framestart    (framestart),
    .linestart     (linestart),
    .prefetch_line (prefetch_line),
    .de            (de),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_line      (req_line),
    .px_valid      (px_valid),
    .px_ready      (px_ready),
    .px_data       (px_data),
    .d_red         (d_red),
    .d_green       (d_green),
    .d_blue        (d_blue),
    .err_underrun  (err_underrun),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          exp_line = 0;
  bit          exp_err  = 1'b0;
  bit          in_fill  = 1'b0;
  bit          req_open = 1'b0;
  logic [23:0] fetched[$];
  logic [23:0] shown[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_line = 0;
    exp_err  = 1'b0;
    in_fill  = 1'b0;
    req_open = 1'b0;
    fetched.delete();
  endtask

  task automatic fetch_line(input int n, input int delay, input bit fs_on_hs, input bit seq);
    prefetch_line = 1'b1;
    step();
    prefetch_line = 1'b0;
    total++;
    if (req_valid !== 1'b1) begin
      bad++;
      $display("FAIL req_valid_assert: got %b want 1", req_valid);
    end
    req_open = 1'b1;
    repeat (delay) step();
    req_ready  = 1'b1;
    framestart = fs_on_hs;
    total++;
    if (req_line !== 10'(exp_line)) begin
      bad++;
      $display("FAIL req_line: got %0d want %0d", req_line, exp_line);
    end
    step();
    req_ready  = 1'b0;
    framestart = 1'b0;
    req_open   = 1'b0;
    in_fill    = 1'b1;
    exp_line   = fs_on_hs ? 0 : (exp_line + 1) % V;
    total++;
    if (px_ready !== 1'b1) begin
      bad++;
      $display("FAIL px_ready_fill: got %b want 1", px_ready);
    end
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) step();
      px_valid = 1'b1;
      px_data  = seq ? 24'(k + 1) : 24'($urandom());
      fetched.push_back(px_data);
      step();
      px_valid = 1'b0;
    end
    if (n == H) begin
      in_fill = 1'b0;
      total++;
      if (px_ready !== 1'b0) begin
        bad++;
        $display("FAIL px_ready_done: got %b want 0", px_ready);
      end
    end
  endtask

  task automatic display_line(input int n_de, input int late);
    logic [23:0] exp_px;
    linestart = 1'b1;
    step();
    linestart = 1'b0;
    if (in_fill || req_open) exp_err = 1'b1;
    req_open = 1'b0;
    shown    = fetched;
    fetched.delete();
    total++;
    if (req_valid !== 1'b0) begin
      bad++;
      $display("FAIL req_valid_after_linestart: got %b want 0", req_valid);
    end
    for (int k = 0; k < late; k++) begin
      px_valid = 1'b1;
      px_data  = 24'($urandom());
      total++;
      if (px_ready !== 1'b1) begin
        bad++;
        $display("FAIL px_ready_drain: got %b want 1 (beat %0d)", px_ready, k);
      end
      step();
      px_valid = 1'b0;
    end
    in_fill = 1'b0;
    step();
    for (int i = 0; i < n_de; i++) begin
      de     = 1'b1;
      exp_px = (i < shown.size()) ? shown[i] : UC;
      if (i >= shown.size()) exp_err = 1'b1;
      total++;
      if ({d_red, d_green, d_blue} !== exp_px) begin
        bad++;
        $display("FAIL pixel[%0d]: got %h want %h", i, {d_red, d_green, d_blue}, exp_px);
      end
      step();
    end
    de     = 1'b0;
    exp_px = (n_de < shown.size()) ? shown[n_de] : UC;
    step();
    total++;
    if ({d_red, d_green, d_blue} !== exp_px) begin
      bad++;
      $display("FAIL pixel_hold: got %h want %h", {d_red, d_green, d_blue}, exp_px);
    end
    total++;
    if (err_underrun !== exp_err) begin
      bad++;
      $display("FAIL err_after_line: got %b want %b", err_underrun, exp_err);
    end
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    exp_err = 1'b0;
    total++;
    if (err_underrun !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: got %b want 0", err_underrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    total += 5;
    if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
    if (req_line !== 10'd0) begin bad++; $display("FAIL rst_req_line: got %0d want 0", req_line); end
    if (px_ready !== 1'b0) begin bad++; $display("FAIL rst_px_ready: got %b want 0", px_ready); end
    if ({d_red, d_green, d_blue} !== 24'h0) begin
      bad++;
      $display("FAIL rst_pixel: got %h want 000000", {d_red, d_green, d_blue});
    end
    if (err_underrun !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_underrun); end
    rst = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_basic();
    fetch_line(H, 1, 1'b0, 1'b1);
    display_line(H, 0);
  endtask

  task automatic test_line_index();
    framestart = 1'b1;
    step();
    framestart = 1'b0;
    exp_line = 0;
    for (int l = 0; l < 4; l++) begin
      fetch_line(H, $urandom_range(0, 3), 1'b0, 1'b0);
      display_line(H, 0);
    end
    fetch_line(H, 1, 1'b1, 1'b0);
    display_line(H, 0);
    fetch_line(H, 0, 1'b0, 1'b0);
    display_line(H, 0);
  endtask

  task automatic test_partial();
    fetch_line(5, 0, 1'b0, 1'b0);
    display_line(H, H - 5);
    clear_err();
    fetch_line(H, 2, 1'b0, 1'b0);
    display_line(H, 0);
  endtask

  task automatic test_req_timeout();
    prefetch_line = 1'b1;
    step();
    prefetch_line = 1'b0;
    req_open = 1'b1;
    repeat (3) step();
    total++;
    if (req_valid !== 1'b1) begin
      bad++;
      $display("FAIL req_valid_held: got %b want 1", req_valid);
    end
    display_line(H, 0);
    clear_err();
    fetch_line(H, 0, 1'b0, 1'b0);
    display_line(H, 0);
  endtask

  task automatic test_reset_mid_fill();
    fetch_line(4, 0, 1'b0, 1'b0);
    prefetch_line = 1'b1;
    step();
    prefetch_line = 1'b0;
    total++;
    if (err_underrun !== 1'b1) begin
      bad++;
      $display("FAIL err_prefetch_busy: got %b want 1", err_underrun);
    end
    #2;
    rst = 1'b0;
    #1;
    total += 5;
    if (req_valid !== 1'b0) begin bad++; $display("FAIL midrst_req_valid: got %b want 0", req_valid); end
    if (req_line !== 10'd0) begin bad++; $display("FAIL midrst_req_line: got %0d want 0", req_line); end
    if (px_ready !== 1'b0) begin bad++; $display("FAIL midrst_px_ready: got %b want 0", px_ready); end
    if ({d_red, d_green, d_blue} !== 24'h0) begin
      bad++;
      $display("FAIL midrst_pixel: got %h want 000000", {d_red, d_green, d_blue});
    end
    if (err_underrun !== 1'b0) begin
      bad++;
      $display("FAIL midrst_err: got %b want 0", err_underrun);
    end
    step();
    rst = 1'b1;
    model_reset();
    step();
    fetch_line(H, 1, 1'b0, 1'b0);
    display_line(H, 0);
  endtask

  task automatic test_clr_err();
    // Line start with nothing fetched: every displayed pixel is an underrun.
    linestart = 1'b1;
    step();
    linestart = 1'b0;
    step();
    step();
    de = 1'b1;
    total++;
    if ({d_red, d_green, d_blue} !== UC) begin
      bad++;
      $display("FAIL empty_pixel: got %h want %h", {d_red, d_green, d_blue}, UC);
    end
    step();
    de = 1'b0;
    total++;
    if (err_underrun !== 1'b1) begin
      bad++;
      $display("FAIL err_empty_line: got %b want 1", err_underrun);
    end
    clear_err();
    step();
    total++;
    if (err_underrun !== 1'b0) begin
      bad++;
      $display("FAIL err_stays_clear: got %b want 0", err_underrun);
    end
    de      = 1'b1;
    clr_err = 1'b1;
    step();
    de      = 1'b0;
    clr_err = 1'b0;
    total++;
    if (err_underrun !== 1'b1) begin
      bad++;
      $display("FAIL err_set_wins: got %b want 1", err_underrun);
    end
    clear_err();
  endtask

  task automatic test_overrun_de();
    fetch_line(H, 0, 1'b0, 1'b0);
    display_line(H + 2, 0);
    clear_err();
  endtask

  task automatic test_random_lines();
    int n;
    for (int l = 0; l < 8; l++) begin
      n = $urandom_range(0, H);
      fetch_line(n, $urandom_range(0, 3), 1'b0, 1'b0);
      display_line(H, H - n);
      if (exp_err) clear_err();
    end
  endtask

  initial begin
    rst           = 1'b0;
    framestart    = 1'b0;
    linestart     = 1'b0;
    prefetch_line = 1'b0;
    de            = 1'b0;
    req_ready     = 1'b0;
    px_valid      = 1'b0;
    px_data       = '0;
    clr_err       = 1'b0;
    test_reset();
    test_basic();
    test_line_index();
    test_partial();
    test_req_timeout();
    test_reset_mid_fill();
    test_clr_err();
    test_overrun_de();
    test_random_lines();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
